// File: rtl/matrix_engine_ctrl.sv
// Matrix engine sequencer: reads A (and B) from RAM, computes an element-wise,
// scalar, transpose, negate or matrix product, then writes one result word back.
module matrix_engine_ctrl #(
    parameter int DIM    = 5,
    parameter int EW     = 8,
    parameter int MEM_W  = 256,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_r,
    input  logic [MEM_W-1:0]  mem_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [MEM_W-1:0]  mem_wdata,
    output logic              mem_wren,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              overflow
);
    localparam int NE = DIM * DIM;
    localparam int PW = NE * EW;
    localparam int WW = 2 * EW + 1;
    localparam int AW = 2 * EW + 3;
    localparam int CW = $clog2(NE + 1);
    localparam int RW = $clog2(DIM + 1);
    localparam int LW = $clog2(RD_LAT + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_SCL = 3'd3;
    localparam logic [2:0] OP_TRN = 3'd4;
    localparam logic [2:0] OP_NEG = 3'd5;

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, COMPUTE, WRITE, DONE} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        opcode_reg;
    logic [ADDR_W-1:0] base_a_reg, base_b_reg, base_r_reg;
    logic [PW-1:0]     a_reg, b_reg, result_reg;
    logic [LW-1:0]     lat_cnt_reg;
    logic [CW-1:0]     elem_cnt_reg;
    logic [RW-1:0]     row_reg, col_reg;
    logic              error_reg, overflow_reg;

    logic rd_last, op_invalid, op_unary, mac_last;
    assign rd_last    = (lat_cnt_reg == LW'(RD_LAT));
    assign op_invalid = (opcode_reg[2:1] == 2'b11);
    assign op_unary   = (opcode_reg == OP_TRN) || (opcode_reg == OP_NEG);
    assign mac_last   = (elem_cnt_reg == CW'(NE - 1));

    // Bits of the RAM word above the packed matrix carry nothing.
    generate
        if (MEM_W > PW) begin : g_pad
            logic unused_rdata;
            assign unused_rdata = ^mem_rdata[MEM_W-1:PW];
        end
    endgenerate

    // Single-cycle operations: every element computed exactly, then wrapped.
    logic [PW-1:0] single_res;
    logic [NE-1:0] single_ovf;

    for (genvar gi = 0; gi < NE; gi++) begin : g_elem
        localparam int E_ROW = gi / DIM;
        localparam int E_COL = gi % DIM;
        localparam int T_IDX = E_COL * DIM + E_ROW;

        logic signed [EW-1:0] a_e, b_e, at_e, s_e;
        logic signed [WW-1:0] wide;

        assign a_e  = a_reg[gi*EW +: EW];
        assign b_e  = b_reg[gi*EW +: EW];
        assign at_e = a_reg[T_IDX*EW +: EW];
        assign s_e  = b_reg[EW-1:0];

        always_comb begin
            case (opcode_reg)
                OP_ADD:  wide = WW'(a_e) + WW'(b_e);
                OP_SUB:  wide = WW'(a_e) - WW'(b_e);
                OP_SCL:  wide = WW'(a_e) * WW'(s_e);
                OP_TRN:  wide = WW'(at_e);
                OP_NEG:  wide = -WW'(a_e);
                default: wide = '0;
            endcase
        end

        assign single_res[gi*EW +: EW] = wide[EW-1:0];
        assign single_ovf[gi] = (wide != WW'($signed(wide[EW-1:0])));
    end

    // Matrix product: one dot product per cycle at the current (row, col).
    logic signed [AW-1:0] mac_sum;
    logic                 mac_ovf;

    always_comb begin
        mac_sum = '0;
        for (int k = 0; k < DIM; k++) begin
            mac_sum = mac_sum
                + AW'($signed(a_reg[(int'(row_reg) * DIM + k) * EW +: EW]))
                * AW'($signed(b_reg[(k * DIM + int'(col_reg)) * EW +: EW]));
        end
    end
    assign mac_ovf = (mac_sum != AW'($signed(mac_sum[EW-1:0])));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // An invalid opcode spends one idle cycle in COMPUTE so that done lands
    // two cycles after accept without touching the RAM.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (opcode[2:1] == 2'b11) ? COMPUTE : RD_A;
                end
            end
            RD_A: begin
                if (rd_last) begin
                    state_next = op_unary ? COMPUTE : RD_B;
                end
            end
            RD_B: begin
                if (rd_last) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (op_invalid) begin
                    state_next = DONE;
                end else if (opcode_reg != OP_MUL || mac_last) begin
                    state_next = WRITE;
                end
            end
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        mem_wren    = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        case (state_reg)
            RD_A: begin
                busy        = 1'b1;
                mem_address = base_a_reg;
            end
            RD_B: begin
                busy        = 1'b1;
                mem_address = base_b_reg;
            end
            COMPUTE: busy = 1'b1;
            WRITE: begin
                busy        = 1'b1;
                mem_wren    = 1'b1;
                mem_address = base_r_reg;
                mem_wdata   = MEM_W'(result_reg);
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign error    = error_reg;
    assign overflow = overflow_reg;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            opcode_reg   <= '0;
            base_a_reg   <= '0;
            base_b_reg   <= '0;
            base_r_reg   <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            result_reg   <= '0;
            lat_cnt_reg  <= '0;
            elem_cnt_reg <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            error_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        opcode_reg   <= opcode;
                        base_a_reg   <= base_a;
                        base_b_reg   <= base_b;
                        base_r_reg   <= base_r;
                        error_reg    <= (opcode[2:1] == 2'b11);
                        overflow_reg <= 1'b0;
                        lat_cnt_reg  <= '0;
                        elem_cnt_reg <= '0;
                        row_reg      <= '0;
                        col_reg      <= '0;
                    end
                end
                RD_A, RD_B: begin
                    if (rd_last) begin
                        lat_cnt_reg <= '0;
                        if (state_reg == RD_A) begin
                            a_reg <= mem_rdata[PW-1:0];
                        end else begin
                            b_reg <= mem_rdata[PW-1:0];
                        end
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + LW'(1);
                    end
                end
                COMPUTE: begin
                    if (opcode_reg == OP_MUL) begin
                        result_reg[int'(elem_cnt_reg) * EW +: EW] <= mac_sum[EW-1:0];
                        if (mac_ovf) begin
                            overflow_reg <= 1'b1;
                        end
                        elem_cnt_reg <= elem_cnt_reg + CW'(1);
                        if (col_reg == RW'(DIM - 1)) begin
                            col_reg <= '0;
                            row_reg <= row_reg + RW'(1);
                        end else begin
                            col_reg <= col_reg + RW'(1);
                        end
                    end else if (!op_invalid) begin
                        result_reg <= single_res;
                        if (|single_ovf) begin
                            overflow_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_engine_ctrl.sv
// Directed bench for matrix_engine_ctrl at default parameters, with a
// behavioural RAM of two-cycle read latency.
module tb_matrix_engine_ctrl;
    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   opcode = '0;
    logic [7:0]   base_a = '0, base_b = '0, base_r = '0;
    logic [255:0] mem_rdata;
    logic [7:0]   mem_address;
    logic [255:0] mem_wdata;
    logic         mem_wren, busy, done, error, overflow;

    int vectors = 0;
    int miscompares = 0;

    matrix_engine_ctrl dut (
        .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode),
        .base_a(base_a), .base_b(base_b), .base_r(base_r),
        .mem_rdata(mem_rdata), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_wren(mem_wren), .busy(busy), .done(done), .error(error),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    logic [255:0] ram [256];
    logic [255:0] pipe1, pipe2;
    int           wr_count = 0;
    int           addr_nz = 0;
    int           hits51 = 0;
    logic [7:0]   wr_addr;
    assign mem_rdata = pipe2;

    always @(posedge clock) begin
        if (mem_wren) begin
            ram[mem_address] = mem_wdata;
            wr_count = wr_count + 1;
            wr_addr = mem_address;
        end
        if (mem_address != 8'd0) addr_nz = addr_nz + 1;
        if (mem_address == 8'd51) hits51 = hits51 + 1;
        pipe1 <= ram[mem_address];
        pipe2 <= pipe1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] fill(input logic [7:0] v);
        logic [255:0] w;
        w = '0;
        for (int i = 0; i < 25; i++) w[i*8 +: 8] = v;
        return w;
    endfunction

    // Runs one operation; n is the cycle (1 = first after accept) in which done
    // is seen, nb the number of busy cycles. pulse_at re-pulses start mid-run.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] r, input int pulse_at,
                          output int n, output int nb);
        opcode = op; base_a = a; base_b = b; base_r = r; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        n = 1;
        nb = 0;
        while (!done && n < 200) begin
            if (busy) nb++;
            if (n == pulse_at) begin
                start = 1'b1; opcode = 3'd5; base_a = 8'd98; base_r = 8'd99;
            end else if (pulse_at != 0 && n == pulse_at + 1) begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            n++;
        end
        @(posedge clock); #1;
    endtask

    logic [255:0] w_id, w_idx, w_trn, w_opp, w_a3, w_scl, w_exp;
    int n, nb, w0, z0, h0;

    initial begin
        w_id = '0; w_idx = '0; w_trn = '0;
        for (int r = 0; r < 5; r++) begin
            w_id[(r*6)*8 +: 8] = 8'd1;
            for (int c = 0; c < 5; c++) begin
                w_idx[(r*5+c)*8 +: 8] = 8'(r*5 + c);
                w_trn[(r*5+c)*8 +: 8] = 8'(c*5 + r);
            end
        end
        w_opp = fill(8'd1);  w_opp[7:0] = 8'h80;
        w_a3 = fill(8'd3);   w_a3[255:200] = '1;
        w_scl = fill(8'd9);  w_scl[7:0] = 8'd3;
        ram[10] = w_a3;        ram[11] = fill(8'd4);
        ram[12] = fill(8'h80); ram[13] = fill(8'd1);
        ram[14] = fill(8'd2);  ram[15] = w_scl;
        ram[16] = w_idx;
        ram[30] = w_id;        ram[31] = w_idx;
        ram[50] = w_opp;       ram[51] = fill(8'h55);

        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_wren", mem_wren, 1'b0);
        check("rst_address", mem_address, 8'd0);
        check("rst_wdata", mem_wdata, 256'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        w0 = wr_count;
        run_op(3'd0, 8'd10, 8'd11, 8'd20, 0, n, nb);
        check("add_latency", n, 9);
        check("add_busy", nb, 8);
        check("add_writes", wr_count - w0, 1);
        check("add_wr_addr", wr_addr, 8'd20);
        check("add_result", ram[20], fill(8'd7));
        check("add_overflow", overflow, 1'b0);
        check("add_error", error, 1'b0);

        w0 = wr_count;
        run_op(3'd2, 8'd30, 8'd31, 8'd40, 0, n, nb);
        check("mul_latency", n, 33);
        check("mul_busy", nb, 32);
        check("mul_writes", wr_count - w0, 1);
        check("mul_result", ram[40], w_idx);
        check("mul_overflow", overflow, 1'b0);

        h0 = hits51;
        run_op(3'd5, 8'd50, 8'd51, 8'd60, 0, n, nb);
        w_exp = fill(8'hFF); w_exp[7:0] = 8'h80;
        check("opp_latency", n, 6);
        check("opp_result", ram[60], w_exp);
        check("opp_overflow", overflow, 1'b1);
        check("opp_no_b_read", hits51 - h0, 0);

        w0 = wr_count; z0 = addr_nz;
        run_op(3'd7, 8'd10, 8'd11, 8'd21, 0, n, nb);
        check("inv_latency", n, 2);
        check("inv_error", error, 1'b1);
        check("inv_overflow_cleared", overflow, 1'b0);
        check("inv_writes", wr_count - w0, 0);
        check("inv_no_address", addr_nz - z0, 0);
        repeat (3) @(posedge clock);
        #1;
        check("inv_error_hold", error, 1'b1);

        w0 = wr_count;
        run_op(3'd0, 8'd10, 8'd11, 8'd70, 5, n, nb);
        check("repulse_latency", n, 9);
        check("repulse_writes", wr_count - w0, 1);
        check("repulse_wr_addr", wr_addr, 8'd70);
        check("repulse_result", ram[70], fill(8'd7));
        check("repulse_error_cleared", error, 1'b0);

        run_op(3'd1, 8'd12, 8'd13, 8'd22, 0, n, nb);
        check("sub_result", ram[22], fill(8'h7F));
        check("sub_overflow", overflow, 1'b1);

        run_op(3'd3, 8'd14, 8'd15, 8'd23, 0, n, nb);
        check("scl_result", ram[23], fill(8'd6));
        check("scl_overflow", overflow, 1'b0);

        run_op(3'd4, 8'd16, 8'd0, 8'd24, 0, n, nb);
        check("trn_latency", n, 6);
        check("trn_result", ram[24], w_trn);

        w0 = wr_count;
        opcode = 3'd2; base_a = 8'd30; base_b = 8'd31; base_r = 8'd80; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (11) @(posedge clock);
        #1;
        check("mid_busy_before", busy, 1'b1);
        reset_n = 1'b0;
        @(posedge clock); #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_wren", mem_wren, 1'b0);
        check("mid_rst_address", mem_address, 8'd0);
        check("mid_rst_wdata", mem_wdata, 256'd0);
        check("mid_rst_error", error, 1'b0);
        check("mid_rst_overflow", overflow, 1'b0);
        reset_n = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        check("mid_rst_no_write", wr_count - w0, 0);

        run_op(3'd0, 8'd10, 8'd11, 8'd90, 0, n, nb);
        check("post_rst_latency", n, 9);
        check("post_rst_result", ram[90], fill(8'd7));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
